// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: opcode values, slot geometry,
// error codes and the loader state encoding.
package program_loader_pkg;

   localparam int unsigned PARAM_SIZE   = 8;
   localparam int unsigned SLOT_COUNT   = 4;
   localparam int unsigned OPCODE_W     = 3;
   localparam int unsigned RECORD_COUNT = 2 * SLOT_COUNT;

   localparam logic [OPCODE_W-1:0] C_NOP  = 3'd0;
   localparam logic [OPCODE_W-1:0] C_LINE = 3'd1;
   localparam logic [OPCODE_W-1:0] C_INCR = 3'd2;
   localparam logic [OPCODE_W-1:0] C_DCRE = 3'd3;
   localparam logic [OPCODE_W-1:0] C_JUMP = 3'd4;

   typedef enum logic [1:0] {
      ERR_NONE     = 2'b00,
      ERR_OPCODE   = 2'b01,
      ERR_CHECKSUM = 2'b10,
      ERR_TIMEOUT  = 2'b11
   } err_code_e;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_OPCODE = 3'd1,
      ST_PARAM  = 3'd2,
      ST_CHECK  = 3'd3,
      ST_RELOAD = 3'd4
   } loader_state_e;

   // An opcode byte is legal only if the upper bits are clear and the value
   // is one of NOP..JUMP, which together reduce to "byte <= JUMP".
   function automatic logic opcode_valid(input logic [7:0] b);
      return b <= {5'b0, C_JUMP};
   endfunction

endpackage

// File: rtl/program_loader_slot_bank.sv
// Shadow and active program storage. Records 0..3 are X slots, 4..7 are Y
// slots. The shadow is written byte by byte during a frame; the active copy
// only changes on the commit strobe.
module loader_slot_bank
   import program_loader_pkg::*;
(
   input  logic                                clk_i,
   input  logic                                reset_i,
   input  logic                                wr_op_i,
   input  logic                                wr_param_i,
   input  logic [2:0]                          wr_idx_i,
   input  logic [OPCODE_W-1:0]                 wr_opcode_i,
   input  logic [PARAM_SIZE-1:0]               wr_param_data_i,
   input  logic                                commit_i,
   output logic [SLOT_COUNT*OPCODE_W-1:0]      x_instr_o,
   output logic [SLOT_COUNT*PARAM_SIZE-1:0]    x_param_o,
   output logic [SLOT_COUNT*OPCODE_W-1:0]      y_instr_o,
   output logic [SLOT_COUNT*PARAM_SIZE-1:0]    y_param_o
);

   logic [OPCODE_W-1:0]   sh_op_q   [RECORD_COUNT];
   logic [PARAM_SIZE-1:0] sh_par_q  [RECORD_COUNT];
   logic [OPCODE_W-1:0]   act_op_q  [RECORD_COUNT];
   logic [PARAM_SIZE-1:0] act_par_q [RECORD_COUNT];

   // Shadow writes during a frame, whole-bank copy to active on commit.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         for (int unsigned i = 0; i < RECORD_COUNT; i++) begin
            sh_op_q[i]   <= '0;
            sh_par_q[i]  <= '0;
            act_op_q[i]  <= '0;
            act_par_q[i] <= '0;
         end
      end else begin
         if (wr_op_i)    sh_op_q[wr_idx_i]  <= wr_opcode_i;
         if (wr_param_i) sh_par_q[wr_idx_i] <= wr_param_data_i;
         if (commit_i) begin
            for (int unsigned i = 0; i < RECORD_COUNT; i++) begin
               act_op_q[i]  <= sh_op_q[i];
               act_par_q[i] <= sh_par_q[i];
            end
         end
      end
   end

   for (genvar k = 0; k < SLOT_COUNT; k++) begin : g_flat
      assign x_instr_o[k*OPCODE_W   +: OPCODE_W]   = act_op_q[k];
      assign x_param_o[k*PARAM_SIZE +: PARAM_SIZE] = act_par_q[k];
      assign y_instr_o[k*OPCODE_W   +: OPCODE_W]   = act_op_q[k+SLOT_COUNT];
      assign y_param_o[k*PARAM_SIZE +: PARAM_SIZE] = act_par_q[k+SLOT_COUNT];
   end

endmodule

// File: rtl/program_loader.sv
// Framed byte-stream program loader for the X/Y wave-gen decoders.
// Frame: SYNC_BYTE, 8 x {opcode, param}, XOR checksum of the 16 payload bytes.
// Optional inter-byte timeout enabled by defining LOADER_TIMEOUT_EN.
module program_loader
   import program_loader_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE      = 8'hA5,
   parameter int         RELOAD_CYCLES  = 2,
   parameter int         TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [11:0] x_instructions_flat,
   output logic [31:0] x_params_flat,
   output logic [11:0] y_instructions_flat,
   output logic [31:0] y_params_flat,
   output logic        decoder_reset,
   output logic        prog_valid,
   output logic        error,
   output logic [1:0]  err_code
);

   if (RELOAD_CYCLES < 1 || RELOAD_CYCLES > 15) begin : g_bad_reload
      $error("RELOAD_CYCLES out of range 1..15");
   end
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES out of range 1..65535");
   end

   localparam logic [3:0] RELOAD_LAST = 4'(RELOAD_CYCLES - 1);

   loader_state_e state_q, state_d;
   logic [2:0]    slot_q, slot_d;
   logic [7:0]    csum_q, csum_d;
   logic [3:0]    rcnt_q, rcnt_d;
   logic          ready_q, ready_d;
   logic          dreset_q, dreset_d;
   logic          pvalid_q, pvalid_d;
   logic          error_q, error_d;
   err_code_e     errc_q, errc_d;

   logic          accept;
   logic          wr_op;
   logic          wr_param;
   logic          commit;

`ifdef LOADER_TIMEOUT_EN
   localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0]   tmo_q, tmo_d;
`endif

   assign accept = in_valid && ready_q;

   // Frame parser: next state, shadow write enables, checksum and strobes.
   always_comb begin
      state_d  = state_q;
      slot_d   = slot_q;
      csum_d   = csum_q;
      rcnt_d   = rcnt_q;
      dreset_d = dreset_q;
      pvalid_d = pvalid_q;
      error_d  = 1'b0;
      errc_d   = errc_q;
      wr_op    = 1'b0;
      wr_param = 1'b0;
      commit   = 1'b0;
`ifdef LOADER_TIMEOUT_EN
      tmo_d    = '0;
`endif

      unique case (state_q)
         ST_IDLE: begin
            if (accept && in_data == SYNC_BYTE) begin
               slot_d  = '0;
               csum_d  = '0;
               state_d = ST_OPCODE;
            end
         end
         ST_OPCODE: begin
            if (accept) begin
               if (opcode_valid(in_data)) begin
                  wr_op   = 1'b1;
                  csum_d  = csum_q ^ in_data;
                  state_d = ST_PARAM;
               end else begin
                  error_d = 1'b1;
                  errc_d  = ERR_OPCODE;
                  state_d = ST_IDLE;
               end
            end
         end
         ST_PARAM: begin
            if (accept) begin
               wr_param = 1'b1;
               csum_d   = csum_q ^ in_data;
               if (slot_q == 3'd7) begin
                  state_d = ST_CHECK;
               end else begin
                  slot_d  = slot_q + 3'd1;
                  state_d = ST_OPCODE;
               end
            end
         end
         ST_CHECK: begin
            if (accept) begin
               if (in_data == csum_q) begin
                  commit   = 1'b1;
                  pvalid_d = 1'b1;
                  dreset_d = 1'b1;
                  rcnt_d   = RELOAD_LAST;
                  state_d  = ST_RELOAD;
               end else begin
                  error_d = 1'b1;
                  errc_d  = ERR_CHECKSUM;
                  state_d = ST_IDLE;
               end
            end
         end
         ST_RELOAD: begin
            if (rcnt_q == '0) begin
               dreset_d = 1'b0;
               state_d  = ST_IDLE;
            end else begin
               rcnt_d = rcnt_q - 4'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

`ifdef LOADER_TIMEOUT_EN
      // Every state entry inside a frame coincides with an accepted byte,
      // so clearing on accept also covers clearing on entry.
      if ((state_q == ST_OPCODE || state_q == ST_PARAM || state_q == ST_CHECK)
          && !accept) begin
         if (tmo_q == TIMEOUT_LAST) begin
            error_d = 1'b1;
            errc_d  = ERR_TIMEOUT;
            state_d = ST_IDLE;
         end else begin
            tmo_d = tmo_q + 16'd1;
         end
      end
`endif

      ready_d = (state_d != ST_RELOAD);
   end

   // Loader control registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         slot_q   <= '0;
         csum_q   <= '0;
         rcnt_q   <= '0;
         ready_q  <= 1'b1;
         dreset_q <= 1'b0;
         pvalid_q <= 1'b0;
         error_q  <= 1'b0;
         errc_q   <= ERR_NONE;
`ifdef LOADER_TIMEOUT_EN
         tmo_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         slot_q   <= slot_d;
         csum_q   <= csum_d;
         rcnt_q   <= rcnt_d;
         ready_q  <= ready_d;
         dreset_q <= dreset_d;
         pvalid_q <= pvalid_d;
         error_q  <= error_d;
         errc_q   <= errc_d;
`ifdef LOADER_TIMEOUT_EN
         tmo_q    <= tmo_d;
`endif
      end
   end

   loader_slot_bank u_bank (
      .clk_i           (clk),
      .reset_i         (reset),
      .wr_op_i         (wr_op),
      .wr_param_i      (wr_param),
      .wr_idx_i        (slot_q),
      .wr_opcode_i     (in_data[OPCODE_W-1:0]),
      .wr_param_data_i (in_data),
      .commit_i        (commit),
      .x_instr_o       (x_instructions_flat),
      .x_param_o       (x_params_flat),
      .y_instr_o       (y_instructions_flat),
      .y_param_o       (y_params_flat)
   );

   assign in_ready      = ready_q;
   assign decoder_reset = dreset_q;
   assign prog_valid    = pvalid_q;
   assign error         = error_q;
   assign err_code      = errc_q;

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Byte-stream writer for the vector-drawing instruction decoders.
- Receives a framed program over a valid/ready byte interface and validates opcodes and checksum.
- On success, commits four X slots and four Y slots onto the flat instruction/param buses that feed the two wave-gen FSMs.
- Pulses a reload strobe so both FSMs latch the new program.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- RELOAD_CYCLES, 2, number of cycles decoder_reset is held high after a commit (1..15).
- TIMEOUT_CYCLES, 255, inter-byte timeout, used only with LOADER_TIMEOUT_EN (1..65535).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- in_data  in  8  stream byte
- in_valid  in  1  in_data valid
- in_ready  out  1  loader can accept a byte
- x_instructions_flat  out  12  slot k opcode at [k*3+:3]
- x_params_flat  out  32  slot k param at [k*8+:8]
- y_instructions_flat  out  12  same layout, Y channel
- y_params_flat  out  32  same layout, Y channel
- decoder_reset  out  1  reload strobe to both wave-gen FSMs
- prog_valid  out  1  at least one program committed since reset
- error  out  1  one-cycle error pulse
- err_code  out  2  01 bad opcode, 10 bad checksum, 11 timeout; held until next error

Behaviour:
- One clock domain. Reset is synchronous and active-high on clk/reset.
- Reset values: all flat outputs 0 (all-NOP program), decoder_reset 0, prog_valid 0, error 0, err_code 0, state IDLE. Shadow registers, slot counter and checksum are cleared.
- Byte accepted when in_valid && in_ready. in_ready is 1 in every state except RELOAD; it is registered from the state.
- Frame format: SYNC_BYTE, then 8 records of {opcode byte, param byte}, then checksum byte.
  - Records 0-3 are X slots 0-3; records 4-7 are Y slots 0-3.
  - Opcode byte [2:0] holds the opcode; [7:3] must be 0.
  - Checksum = XOR of the 16 payload bytes; SYNC_BYTE is not included.
- States:
  - IDLE: any accepted byte other than SYNC_BYTE is dropped silently. SYNC_BYTE clears the slot counter (3 bits) and checksum, then goes to OPCODE.
  - OPCODE: accepted byte is checked. Valid if value <= 4 (NOP, LINE, INCR, DCRE, JUMP). Invalid → pulse error, err_code=01, go to IDLE. Valid → write shadow opcode, XOR into checksum, go to PARAM.
  - PARAM: write shadow param, XOR into checksum. Slot counter == 7 → CHECK; else increment the counter and go to OPCODE.
  - CHECK: accepted byte == running checksum → COMMIT action; else pulse error, err_code=10, go to IDLE. The active program is left unchanged.
  - COMMIT action, in the cycle after the checksum byte is accepted:
    - copy shadow to all four flat outputs;
    - set prog_valid=1 (sticky);
    - raise decoder_reset;
    - enter RELOAD.
  - RELOAD: decoder_reset stays high for exactly RELOAD_CYCLES cycles, in_ready=0, then go to IDLE with decoder_reset=0.
- Flat outputs change only at COMMIT, never mid-frame. Aborted frames leave the outputs unchanged.
- SYNC_BYTE appearing inside a frame is treated as data; there is no resync.
- Reset mid-frame or mid-RELOAD: all state returns to reset values immediately, including outputs going to 0 and decoder_reset dropping.
- error is high for exactly one cycle per failure. A new frame may start in the cycle after an error.

Optional Feature:
- Macro LOADER_TIMEOUT_EN.
- Defined: a 16-bit idle counter runs in OPCODE, PARAM and CHECK.
  - It clears on every accepted byte and on each state entry.
  - When it reaches TIMEOUT_CYCLES: pulse error, err_code=11, go to IDLE, shadow discarded.
- Undefined: no counter; the loader waits indefinitely mid-frame and err_code 11 is never produced.

Decomposition:
- Shared package holds:
  - opcode constants C_NOP=0, C_LINE=1, C_INCR=2, C_DCRE=3, C_JUMP=4;
  - PARAM_SIZE=8, SLOT_COUNT=4;
  - err_code constants;
  - loader state encoding.
- One sub-module, loader_slot_bank: shadow and active register arrays with a write port (slot index, opcode, param) and a commit strobe. The FSM, checksum and timeout live in the top level.

Test Plan:
- Good frame: A5, 04 FA, 03 64, 02 5A, 00 00, 04 0A, 02 64, 03 5A, 00 00, F0.
  - Expect x_instructions_flat=12'h09C, x_params_flat=32'h005A64FA.
  - Expect y_instructions_flat=12'h0D4, y_params_flat=32'h005A640A.
  - Expect prog_valid=1, and decoder_reset high 2 cycles with in_ready=0.
- Same frame with checksum 0xF1 → one-cycle error, err_code=10, outputs keep their previous values, no decoder_reset.
- Third opcode byte 0x05 → error, err_code=01 at that byte. Remaining bytes are dropped in IDLE until the next A5.
- Leading garbage 00 FF 13 before A5 plus the good frame → ignored, frame commits normally. With in_valid toggled randomly, the result is identical.
- Reset asserted after 5 payload bytes, then the good frame sent → outputs 0 after reset, then the correct commit.
- With LOADER_TIMEOUT_EN and TIMEOUT_CYCLES=20: stall 20 cycles after A5 → error, err_code=11, IDLE. A following good frame commits.
